// File: rtl/decode_stage_pkg.sv
// Shared decode types: ALU operations, immediate formats, opcodes and the decoded bundle.
package decode_stage_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        alu_op_e    alu_op;
        imm_type_e  imm_type;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src_imm;
        logic       illegal;
    } dec_bundle_t;

    function automatic alu_op_e base_alu_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e mext_alu_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_MUL;
            3'd1:    return ALU_MULH;
            3'd2:    return ALU_MULHSU;
            3'd3:    return ALU_MULHU;
            3'd4:    return ALU_DIV;
            3'd5:    return ALU_DIVU;
            3'd6:    return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I(+M) instruction decoder producing one dec_bundle_t.
module rv_decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit EN_MEXT = 1'b0
) (
    input  logic [31:0] i_inst,
    output dec_bundle_t o_dec
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       use_rd, use_rs1, use_rs2, legal;
    logic       reg_wr, mem_rd, mem_wr, br, jmp, jr, src_imm;
    alu_op_e    alu_op;
    imm_type_e  imm_type;

    assign opc = i_inst[6:0];
    assign f3  = i_inst[14:12];
    assign f7  = i_inst[31:25];

    always_comb begin
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        legal    = 1'b0;
        reg_wr   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        br       = 1'b0;
        jmp      = 1'b0;
        jr       = 1'b0;
        src_imm  = 1'b0;
        alu_op   = ALU_ADD;
        imm_type = IMM_I;
        case (opc)
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                reg_wr  = 1'b1;
                if (f7 == F7_BASE) begin
                    legal  = 1'b1;
                    alu_op = base_alu_op(f3);
                end else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) begin
                    legal  = 1'b1;
                    alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                end else if (f7 == F7_MEXT) begin
                    legal  = EN_MEXT;
                    alu_op = mext_alu_op(f3);
                end
            end
            OPC_OPIMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                reg_wr  = 1'b1;
                src_imm = 1'b1;
                alu_op  = base_alu_op(f3);
                if (f3 == 3'd1) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'd5) begin
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    if (f7 == F7_ALT) alu_op = ALU_SRA;
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                reg_wr  = 1'b1;
                mem_rd  = 1'b1;
                src_imm = 1'b1;
                legal   = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            OPC_STORE: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                mem_wr   = 1'b1;
                src_imm  = 1'b1;
                imm_type = IMM_S;
                legal    = (f3 < 3'd3);
            end
            OPC_BRANCH: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                br       = 1'b1;
                imm_type = IMM_B;
                alu_op   = ALU_SUB;
                legal    = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_JAL: begin
                use_rd   = 1'b1;
                reg_wr   = 1'b1;
                jmp      = 1'b1;
                imm_type = IMM_J;
                legal    = 1'b1;
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                reg_wr  = 1'b1;
                jr      = 1'b1;
                src_imm = 1'b1;
                legal   = (f3 == 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd   = 1'b1;
                reg_wr   = 1'b1;
                src_imm  = 1'b1;
                imm_type = IMM_U;
                legal    = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Illegal words keep their format fields but lose every side-effecting control.
        o_dec             = '0;
        o_dec.rd          = use_rd  ? i_inst[11:7]  : 5'd0;
        o_dec.rs1         = use_rs1 ? i_inst[19:15] : 5'd0;
        o_dec.rs2         = use_rs2 ? i_inst[24:20] : 5'd0;
        o_dec.funct3      = f3;
        o_dec.alu_op      = legal ? alu_op : ALU_ADD;
        o_dec.imm_type    = imm_type;
        o_dec.alu_src_imm = src_imm;
        o_dec.illegal     = !legal;
        o_dec.reg_write   = legal && reg_wr && (i_inst[11:7] != 5'd0);
        o_dec.mem_read    = legal && mem_rd;
        o_dec.mem_write   = legal && mem_wr;
        o_dec.branch      = legal && br;
        o_dec.jump        = legal && jmp;
        o_dec.jalr        = legal && jr;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: OUT + SKID entries, load-use bubbling and flush around rv_decode_comb.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_MEXT = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_regWrite,
    output logic            o_memRead,
    output logic            o_memWrite,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_jalr,
    output logic            o_aluSrcImm,
    output logic [2:0]      o_funct3,
    output alu_op_e         o_aluOp,
    output imm_type_e       o_immType,
    output logic            o_illegal,
    input  logic            i_flush,
    input  logic            i_exMemRead,
    input  logic [4:0]      i_exRd
);

    dec_bundle_t     in_dec;
    dec_bundle_t     out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            accept, fire, haz;

    rv_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
        .i_inst (i_inst),
        .o_dec  (in_dec)
    );

    // Unused source fields are already zero, so index equality alone implies "used".
    assign haz = i_exMemRead && (i_exRd != 5'd0) &&
                 ((i_exRd == out_dec_q.rs1) || (i_exRd == out_dec_q.rs2));

    assign o_ready = !skid_valid_q;
    assign accept  = i_valid && o_ready;
    assign o_valid = out_valid_q && !haz;
    assign fire    = o_valid && i_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_dec_d    = out_dec_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_pc_d    = skid_pc_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (fire) begin
            if (skid_valid_q) begin
                out_dec_d    = skid_dec_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_dec_d = in_dec;
                out_pc_d  = i_pc;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q) begin
                skid_valid_d = 1'b1;
                skid_dec_d   = in_dec;
                skid_pc_d    = i_pc;
            end else begin
                out_valid_d = 1'b1;
                out_dec_d   = in_dec;
                out_pc_d    = i_pc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_dec_q    <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_dec_q   <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_dec_q    <= out_dec_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign o_pc        = out_pc_q;
    assign o_rs1       = out_dec_q.rs1;
    assign o_rs2       = out_dec_q.rs2;
    assign o_rd        = out_dec_q.rd;
    assign o_regWrite  = out_dec_q.reg_write;
    assign o_memRead   = out_dec_q.mem_read;
    assign o_memWrite  = out_dec_q.mem_write;
    assign o_branch    = out_dec_q.branch;
    assign o_jump      = out_dec_q.jump;
    assign o_jalr      = out_dec_q.jalr;
    assign o_aluSrcImm = out_dec_q.alu_src_imm;
    assign o_funct3    = out_dec_q.funct3;
    assign o_aluOp     = out_dec_q.alu_op;
    assign o_immType   = out_dec_q.imm_type;
    assign o_illegal   = out_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus a randomized stream vs. a reference decoder.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid, i_ready, i_flush, i_exMemRead;
    logic [31:0] i_inst, i_pc;
    logic [4:0]  i_exRd;

    logic        o_ready, o_valid, o_regWrite, o_memRead, o_memWrite, o_branch, o_jump, o_jalr;
    logic        o_aluSrcImm, o_illegal;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_funct3;
    alu_op_e     o_aluOp;
    imm_type_e   o_immType;

    logic        m_ready, m_valid, m_regWrite, m_memRead, m_memWrite, m_branch, m_jump, m_jalr;
    logic        m_aluSrcImm, m_illegal;
    logic [31:0] m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_funct3;
    alu_op_e     m_aluOp;
    imm_type_e   m_immType;

    decode_stage #(.XLEN(32), .EN_MEXT(1'b0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
        .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_rs1(o_rs1),
        .o_rs2(o_rs2), .o_rd(o_rd), .o_regWrite(o_regWrite), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_branch(o_branch), .o_jump(o_jump), .o_jalr(o_jalr),
        .o_aluSrcImm(o_aluSrcImm), .o_funct3(o_funct3), .o_aluOp(o_aluOp),
        .o_immType(o_immType), .o_illegal(o_illegal), .i_flush(i_flush),
        .i_exMemRead(i_exMemRead), .i_exRd(i_exRd)
    );

    decode_stage #(.XLEN(32), .EN_MEXT(1'b1)) dut_m (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(m_ready), .i_inst(i_inst),
        .i_pc(i_pc), .o_valid(m_valid), .i_ready(i_ready), .o_pc(m_pc), .o_rs1(m_rs1),
        .o_rs2(m_rs2), .o_rd(m_rd), .o_regWrite(m_regWrite), .o_memRead(m_memRead),
        .o_memWrite(m_memWrite), .o_branch(m_branch), .o_jump(m_jump), .o_jalr(m_jalr),
        .o_aluSrcImm(m_aluSrcImm), .o_funct3(m_funct3), .o_aluOp(m_aluOp),
        .o_immType(m_immType), .o_illegal(m_illegal), .i_flush(i_flush),
        .i_exMemRead(i_exMemRead), .i_exRd(i_exRd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, br, jp, jr, si, ill;
        logic [2:0]  f3;
        alu_op_e     op;
        imm_type_e   it;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_h;
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    logic [31:0] pc_ctr = 32'h1000;

    alu_op_e base_tab[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_e mul_tab[8]  = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference decoder: format table by opcode, legality from the ISA's listed encodings.
    function automatic exp_t ref_decode(input logic [31:0] w, input bit en_m, input logic [31:0] pc);
        exp_t e;
        bit legal, u_rd, u_r1, u_r2, wr, mrd, mwr, b, j, jl, imm;
        logic [6:0] opc = w[6:0];
        logic [6:0] f7  = w[31:25];
        logic [2:0] f3  = w[14:12];
        alu_op_e op = ALU_ADD;
        imm_type_e it = IMM_I;
        {legal, u_rd, u_r1, u_r2, wr, mrd, mwr, b, j, jl, imm} = '0;
        case (opc)
            7'h33: begin
                {u_rd, u_r1, u_r2, wr} = 4'b1111;
                if (f7 == 7'h00) begin legal = 1; op = base_tab[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; op = ALU_SUB; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; op = ALU_SRA; end
                else if (f7 == 7'h01) begin legal = en_m; op = mul_tab[f3]; end
            end
            7'h13: begin
                {u_rd, u_r1, wr, imm} = 4'b1111;
                op = base_tab[f3];
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) op = ALU_SRA;
                end else legal = 1;
            end
            7'h03: begin {u_rd, u_r1, wr, mrd, imm} = 5'b11111; legal = f3 inside {0, 1, 2, 4, 5}; end
            7'h23: begin {u_r1, u_r2, mwr, imm} = 4'b1111; it = IMM_S; legal = f3 inside {0, 1, 2}; end
            7'h63: begin {u_r1, u_r2, b} = 3'b111; it = IMM_B; op = ALU_SUB; legal = !(f3 inside {2, 3}); end
            7'h6F: begin {u_rd, wr, j} = 3'b111; it = IMM_J; legal = 1; end
            7'h67: begin {u_rd, u_r1, wr, jl, imm} = 5'b11111; legal = (f3 == 3'd0); end
            7'h37, 7'h17: begin {u_rd, wr, imm} = 3'b111; it = IMM_U; legal = 1; end
            7'h0F, 7'h73: legal = 1;
            default: legal = 0;
        endcase
        e.pc  = pc;
        e.rd  = u_rd ? w[11:7] : 5'd0;
        e.rs1 = u_r1 ? w[19:15] : 5'd0;
        e.rs2 = u_r2 ? w[24:20] : 5'd0;
        e.f3  = f3;
        e.op  = legal ? op : ALU_ADD;
        e.it  = it;
        e.si  = imm;
        e.ill = !legal;
        e.rw  = legal && wr && (w[11:7] != 5'd0);
        e.mr  = legal && mrd;
        e.mw  = legal && mwr;
        e.br  = legal && b;
        e.jp  = legal && j;
        e.jr  = legal && jl;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [6:0] f7s[4]  = '{7'h00, 7'h20, 7'h01, 7'h7F};
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom_range(0, 7));
        int k = $urandom_range(0, 19);
        if (k == 0) return $urandom();
        return {f7s[$urandom_range(0, 3)], rs2, rs1, f3, rd, opcs[$urandom_range(0, 8)]};
    endfunction

    task automatic step(input logic v, input logic [31:0] inst, input logic rdy,
                        input logic exmr, input logic [4:0] exrd, input logic fl);
        @(negedge i_clk);
        i_valid = v; i_inst = inst; i_pc = pc_ctr; i_ready = rdy;
        i_exMemRead = exmr; i_exRd = exrd; i_flush = fl;
        #2;
        if (fl) sb.delete();
        else if (v && o_ready) begin
            sb.push_back(ref_decode(inst, 1'b0, pc_ctr));
            pc_ctr += 4;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_pc"}, o_pc, 0);
        chk({tag, "_regs"}, {o_rs1, o_rs2, o_rd, o_funct3}, 0);
        chk({tag, "_ctrl"}, {o_regWrite, o_memRead, o_memWrite, o_branch, o_jump, o_jalr,
                             o_aluSrcImm, o_illegal}, 0);
        chk({tag, "_aluop"}, o_aluOp, ALU_ADD);
        chk({tag, "_immtype"}, o_immType, IMM_I);
    endtask

    task automatic chk_out(input exp_t h);
        chk("pc", o_pc, h.pc);
        chk("rs1", o_rs1, h.rs1);
        chk("rs2", o_rs2, h.rs2);
        chk("rd", o_rd, h.rd);
        chk("funct3", o_funct3, h.f3);
        chk("aluop", o_aluOp, h.op);
        chk("immtype", o_immType, h.it);
        chk("illegal", o_illegal, h.ill);
        chk("ctrl", {o_regWrite, o_memRead, o_memWrite, o_branch, o_jump, o_jalr, o_aluSrcImm},
            {h.rw, h.mr, h.mw, h.br, h.jp, h.jr, h.si});
    endtask

    // Monitor: checks handshake against queue occupancy and pops on every non-flushed fire.
    always begin
        @(negedge i_clk);
        #1;
        if (mon_en) begin
            chk("o_valid", o_valid, (sb.size() > 0) &&
                !(i_exMemRead && i_exRd != 5'd0 && (i_exRd == sb[0].rs1 || i_exRd == sb[0].rs2)));
            chk("o_ready", o_ready, sb.size() < 2);
            if (o_valid && i_ready && !i_flush) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: pc %0h presented, expected none", o_pc);
                end else begin
                    mon_h = sb.pop_front();
                    chk_out(mon_h);
                end
            end
        end
    end

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SW   = 32'h0021A423;
    localparam logic [31:0] MUL  = 32'h022081B3;

    initial begin
        logic [31:0] hpc;
        i_valid = 0; i_inst = 0; i_pc = 0; i_ready = 0;
        i_flush = 0; i_exMemRead = 0; i_exRd = 0;
        repeat (2) @(negedge i_clk);
        #1 chk_reset("rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        mon_en = 1'b1;

        // 1: single ADDI
        step(1, ADDI, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t1_valid", o_valid, 1);
        chk("t1_rw_imm", {o_regWrite, o_aluSrcImm}, 2'b11);
        chk("t1_rd", o_rd, 1);
        chk("t1_immtype", o_immType, IMM_I);
        chk("t1_aluop", o_aluOp, ALU_ADD);

        // 2: back-pressure fills both entries, third held upstream
        step(1, ADDI, 0, 0, 0, 0);
        step(1, ADD, 0, 0, 0, 0);
        step(1, SW, 0, 0, 0, 0);
        chk("t2_ready_full", o_ready, 0);
        step(1, SW, 0, 0, 0, 0);
        step(1, SW, 1, 0, 0, 0);
        step(1, SW, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_third_out", o_memWrite, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_drained", sb.size(), 0);

        // 3: load-use stall, then no stall for x0
        hpc = pc_ctr;
        step(1, ADD, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 5'd1, 0);
            chk("t3_stall", o_valid, 0);
        end
        step(0, 0, 1, 0, 5'd1, 0);
        chk("t3_release", o_valid, 1);
        chk("t3_same_pc", o_pc, hpc);
        step(1, ADD, 0, 0, 0, 0);
        step(0, 0, 1, 1, 5'd0, 0);
        chk("t3_x0_nostall", o_valid, 1);
        step(0, 0, 1, 0, 0, 0);

        // 4: flush with both entries full and a pending offer
        step(1, ADDI, 0, 0, 0, 0);
        step(1, ADD, 0, 0, 0, 0);
        step(1, SW, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("t4_valid", o_valid, 0);
        chk("t4_ready", o_ready, 1);
        step(1, ADDI, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // 5: illegal words and the M extension
        step(1, 32'h0000007F, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t5_ill", {o_illegal, o_regWrite}, 2'b10);
        step(1, MUL, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t5_mul_noext", o_illegal, 1);
        chk("t5_mul_op", m_aluOp, ALU_MUL);
        chk("t5_mul_rw", {m_regWrite, m_illegal}, 2'b10);

        // 6: asynchronous reset between edges with both entries full
        step(1, ADDI, 0, 0, 0, 0);
        step(1, ADD, 0, 0, 0, 0);
        step(1, SW, 0, 0, 0, 0);
        #1 i_rst = 1'b1; i_valid = 1'b0;
        #1 chk_reset("t6");
        sb.delete();
        i_rst = 1'b0;

        // Randomized stream
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 70, rand_inst(), $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 25, 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 3);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 1, 0, 0, 0);
        chk("final_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
